// File: rtl/lora_tx_sequencer_if.sv
// lora_tx_sequencer_if: packet request, SPI write handshake and debug signals of the LoRa TX sequencer
interface lora_tx_sequencer_if #(parameter int PAYLOAD_BYTES = 2);
  logic                       start_i;
  logic [8*PAYLOAD_BYTES-1:0] payload_i;
  logic                       spi_busy_i;
  logic                       dio0_i;
  logic                       spi_req_o;
  logic [15:0]                spi_word_o;
  logic                       busy_o;
  logic                       done_o;
  logic                       timeout_o;
  logic [2:0]                 state_o;
  logic [4:0]                 step_o;
  modport master (output start_i, payload_i, spi_busy_i, dio0_i,
                  input spi_req_o, spi_word_o, busy_o, done_o, timeout_o, state_o, step_o);
  modport slave (input start_i, payload_i, spi_busy_i, dio0_i,
                 output spi_req_o, spi_word_o, busy_o, done_o, timeout_o, state_o, step_o);
endinterface

// File: rtl/lora_tx_sequencer.sv
// lora_tx_sequencer: walks the SX1278 register write list for one packet, waits for TxDone, aborts to standby on timeout
module lora_tx_sequencer #(
  parameter int         PAYLOAD_BYTES  = 2,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] PA_CONFIG      = 8'hC0
) (
  input logic               clk,
  input logic               rst,
  lora_tx_sequencer_if.slave io
);
  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] S_PAY = 5'd6;
  localparam logic [4:0] S_GO  = 5'(6 + PAYLOAD_BYTES);
  localparam logic [4:0] S_CLR = 5'(7 + PAYLOAD_BYTES);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] WAIT_TX   = 3'd4;
  localparam logic [2:0] ABORT     = 3'd5;
  localparam logic [2:0] FINISH    = 3'd6;
  logic [2:0]    state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pay_q, pay_d;
  logic [15:0]   word_q, word_d;
  logic          req_q, req_d;
  logic          tmo_q, tmo_d;
  logic          ab_q, ab_d;
  logic [6:0]    addr;
  logic [7:0]    data;
  // payload steps always take the top byte; the register shifts left after each one
  always_comb begin
    addr = 7'h00;
    data = pay_q[PW-1 -: 8];
    case (step_q)
      5'd0:    begin addr = 7'h01; data = 8'h80; end
      5'd1:    begin addr = 7'h01; data = 8'h81; end
      5'd2:    begin addr = 7'h09; data = PA_CONFIG; end
      5'd3:    begin addr = 7'h0E; data = 8'h00; end
      5'd4:    begin addr = 7'h0D; data = 8'h00; end
      5'd5:    begin addr = 7'h22; data = 8'(PAYLOAD_BYTES); end
      S_GO:    begin addr = 7'h01; data = 8'h83; end
      S_CLR:   begin addr = 7'h12; data = 8'h08; end
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    word_d  = word_q;
    req_d   = 1'b0;
    tmo_d   = 1'b0;
    ab_d    = ab_q;
    case (state_q)
      IDLE: if (io.start_i) begin
        pay_d   = io.payload_i;
        step_d  = '0;
        ab_d    = 1'b0;
        state_d = ISSUE;
      end
      ISSUE, ABORT: if (!io.spi_busy_i) begin
        req_d   = 1'b1;
        ab_d    = state_q == ABORT;
        word_d  = state_q == ABORT ? 16'h8181 : {1'b1, addr, data};
        pay_d   = (state_q == ISSUE && step_q >= S_PAY && step_q < S_GO) ? pay_q << 8 : pay_q;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: state_d = io.spi_busy_i ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: if (!io.spi_busy_i) begin
        tmo_d   = ab_q;
        cnt_d   = '0;
        step_d  = (ab_q || step_q == S_GO || step_q == S_CLR) ? step_q : step_q + 5'd1;
        state_d = ab_q ? IDLE : step_q == S_GO ? WAIT_TX : step_q == S_CLR ? FINISH : ISSUE;
      end
      WAIT_TX: begin
        step_d  = io.dio0_i ? S_CLR : step_q;
        cnt_d   = cnt_q + CW'(1);
        state_d = io.dio0_i ? ISSUE : cnt_q == CNT_MAX ? ABORT : WAIT_TX;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      pay_q   <= '0;
      word_q  <= '0;
      req_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      word_q  <= word_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      ab_q    <= ab_d;
    end
  end
  assign io.spi_req_o  = req_q;
  assign io.spi_word_o = word_q;
  assign io.busy_o     = state_q != IDLE;
  assign io.done_o     = state_q == FINISH;
  assign io.timeout_o  = tmo_q;
  assign io.state_o    = state_q;
  assign io.step_o     = step_q;
endmodule

// File: tb/tb_lora_tx_sequencer.sv
// tb_lora_tx_sequencer: directed checks of the TX write list, TxDone timeout, start filtering, reset and payload lengths
module tb_lora_tx_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  int bc0 = 0, bc1 = 0, bc2 = 0, bc3 = 0;
  int dn0 = 0, dn1 = 0, dn2 = 0, dn3 = 0;
  int tm0 = 0, tm1 = 0, tm2 = 0, tm3 = 0;
  logic [15:0] q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  lora_tx_sequencer_if #(.PAYLOAD_BYTES(2))  b0();
  lora_tx_sequencer_if #(.PAYLOAD_BYTES(2))  b1();
  lora_tx_sequencer_if #(.PAYLOAD_BYTES(1))  b2();
  lora_tx_sequencer_if #(.PAYLOAD_BYTES(16)) b3();

  lora_tx_sequencer #(.PAYLOAD_BYTES(2), .TIMEOUT_CYCLES(1000)) u0 (.clk(clk), .rst(rst), .io(b0.slave));
  lora_tx_sequencer #(.PAYLOAD_BYTES(2), .TIMEOUT_CYCLES(50))   u1 (.clk(clk), .rst(rst), .io(b1.slave));
  lora_tx_sequencer #(.PAYLOAD_BYTES(1), .TIMEOUT_CYCLES(1000)) u2 (.clk(clk), .rst(rst), .io(b2.slave));
  lora_tx_sequencer #(.PAYLOAD_BYTES(16), .TIMEOUT_CYCLES(1000)) u3 (.clk(clk), .rst(rst), .io(b3.slave));

  // SPI master models: busy for 16 cycles after each accepted request
  always @(posedge clk) begin
    bc0 <= b0.spi_req_o ? 16 : (bc0 > 0 ? bc0 - 1 : 0);
    bc1 <= b1.spi_req_o ? 16 : (bc1 > 0 ? bc1 - 1 : 0);
    bc2 <= b2.spi_req_o ? 16 : (bc2 > 0 ? bc2 - 1 : 0);
    bc3 <= b3.spi_req_o ? 16 : (bc3 > 0 ? bc3 - 1 : 0);
  end
  assign b0.spi_busy_i = hold || bc0 != 0;
  assign b1.spi_busy_i = bc1 != 0;
  assign b2.spi_busy_i = bc2 != 0;
  assign b3.spi_busy_i = bc3 != 0;

  always @(posedge clk) begin
    #1;
    if (b0.spi_req_o) q0.push_back(b0.spi_word_o);
    if (b1.spi_req_o) q1.push_back(b1.spi_word_o);
    if (b2.spi_req_o) q2.push_back(b2.spi_word_o);
    if (b3.spi_req_o) q3.push_back(b3.spi_word_o);
    dn0 += int'(b0.done_o); dn1 += int'(b1.done_o); dn2 += int'(b2.done_o); dn3 += int'(b3.done_o);
    tm0 += int'(b0.timeout_o); tm1 += int'(b1.timeout_o); tm2 += int'(b2.timeout_o); tm3 += int'(b3.timeout_o);
  end

  task automatic test_reset();
    #1;
    ncmp++; if (b0.spi_req_o !== 1'b0) begin nerr++; $display("FAIL rst_spi_req: got %b want 0", b0.spi_req_o); end
    ncmp++; if (b0.spi_word_o !== 16'h0000) begin nerr++; $display("FAIL rst_spi_word: got %h want 0000", b0.spi_word_o); end
    ncmp++; if (b0.busy_o !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", b0.busy_o); end
    ncmp++; if (b0.done_o !== 1'b0 || b0.timeout_o !== 1'b0) begin nerr++; $display("FAIL rst_pulses: got done=%b timeout=%b want 0 0", b0.done_o, b0.timeout_o); end
    ncmp++; if (b0.state_o !== 3'd0 || b0.step_o !== 5'd0) begin nerr++; $display("FAIL rst_state_step: got %0d/%0d want 0/0", b0.state_o, b0.step_o); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    ncmp++; if (b0.busy_o !== 1'b0 || q0.size() != 0) begin nerr++; $display("FAIL idle_after_rst: got busy=%b reqs=%0d want 0 0", b0.busy_o, q0.size()); end
  endtask

  task automatic test_packet();
    logic [15:0] exp [10] = '{16'h8180, 16'h8181, 16'h89C0, 16'h8E00, 16'h8D00,
                              16'hA202, 16'h80A5, 16'h805A, 16'h8183, 16'h9208};
    int base = q0.size();
    int d = dn0;
    int t = tm0;
    int n = 0;
    b0.payload_i = 16'hA55A; b0.start_i = 1'b1;
    @(negedge clk);
    b0.start_i = 1'b0; b0.payload_i = 16'h1234;
    while (b0.step_o != 5'd3 && n < 200) begin @(negedge clk); n++; end
    b0.payload_i = 16'hFFFF; b0.start_i = 1'b1;
    @(negedge clk);
    b0.start_i = 1'b0;
    n = 0;
    while (q0.size() < base + 9 && n < 500) begin @(negedge clk); n++; end
    ncmp++; if (q0.size() != base + 9) begin nerr++; $display("FAIL pkt_reach_go: got %0d words want 9", q0.size() - base); end
    repeat (99) @(negedge clk);
    ncmp++; if (b0.state_o !== 3'd4) begin nerr++; $display("FAIL pkt_wait_tx: got state %0d want 4", b0.state_o); end
    b0.dio0_i = 1'b1;
    @(negedge clk);
    b0.dio0_i = 1'b0;
    n = 0;
    while (dn0 == d && n < 200) begin @(negedge clk); n++; end
    repeat (40) @(negedge clk);
    ncmp++; if (q0.size() != base + 10) begin nerr++; $display("FAIL pkt_req_count: got %0d want 10", q0.size() - base); end
    for (int i = 0; i < 10; i++) begin
      ncmp++; if (q0[base + i] !== exp[i]) begin nerr++; $display("FAIL pkt_word%0d: got %h want %h", i, q0[base + i], exp[i]); end
    end
    ncmp++; if (dn0 - d != 1 || tm0 != t) begin nerr++; $display("FAIL pkt_pulses: got done=%0d timeout=%0d want 1 0", dn0 - d, tm0 - t); end
    ncmp++; if (b0.busy_o !== 1'b0) begin nerr++; $display("FAIL pkt_busy_end: got %b want 0", b0.busy_o); end
  endtask

  task automatic test_timeout();
    int base = q1.size();
    int d = dn1;
    int t = tm1;
    int n = 0;
    int w = 0;
    b1.payload_i = 16'h0102; b1.start_i = 1'b1;
    @(negedge clk);
    b1.start_i = 1'b0;
    while (q1.size() < base + 9 && n < 500) begin @(negedge clk); n++; end
    ncmp++; if (q1.size() != base + 9 || q1[base + 8] !== 16'h8183) begin nerr++; $display("FAIL to_reach_go: got %0d words want 9 ending 8183", q1.size() - base); end
    n = 0;
    while (b1.state_o != 3'd4 && n < 100) begin @(negedge clk); n++; end
    while (b1.state_o == 3'd4 && w < 200) begin @(negedge clk); w++; end
    ncmp++; if (w != 50) begin nerr++; $display("FAIL to_wait_cycles: got %0d want 50", w); end
    n = 0;
    while (b1.busy_o && n < 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    ncmp++; if (q1.size() != base + 10 || q1[base + 9] !== 16'h8181) begin nerr++; $display("FAIL to_standby_word: got %0d words last %h want 10 last 8181", q1.size() - base, q1[q1.size() - 1]); end
    ncmp++; if (tm1 - t != 1) begin nerr++; $display("FAIL to_pulse: got %0d timeout pulses want 1", tm1 - t); end
    ncmp++; if (dn1 != d) begin nerr++; $display("FAIL to_no_done: got %0d done pulses want 0", dn1 - d); end
    ncmp++; if (b1.busy_o !== 1'b0) begin nerr++; $display("FAIL to_busy_end: got %b want 0", b1.busy_o); end
  endtask

  task automatic test_busy_hold();
    int base = q0.size();
    hold = 1'b1;
    b0.payload_i = 16'hC33C; b0.start_i = 1'b1;
    @(negedge clk);
    b0.start_i = 1'b0;
    repeat (10) @(negedge clk);
    ncmp++; if (q0.size() != base || b0.state_o !== 3'd1) begin nerr++; $display("FAIL hold_no_req: got reqs=%0d state=%0d want 0 1", q0.size() - base, b0.state_o); end
    hold = 1'b0;
    @(negedge clk);
    ncmp++; if (b0.spi_req_o !== 1'b1 || b0.spi_word_o !== 16'h8180) begin nerr++; $display("FAIL hold_release_req: got req=%b word=%h want 1 8180", b0.spi_req_o, b0.spi_word_o); end
    @(negedge clk);
    ncmp++; if (b0.spi_req_o !== 1'b0 || b0.spi_word_o !== 16'h8180) begin nerr++; $display("FAIL hold_single_pulse: got req=%b word=%h want 0 8180", b0.spi_req_o, b0.spi_word_o); end
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    while (!(b0.step_o == 5'd6 && b0.state_o == 3'd3) && n < 500) begin @(negedge clk); n++; end
    ncmp++; if (b0.step_o !== 5'd6 || b0.state_o !== 3'd3) begin nerr++; $display("FAIL mid_reach_step6: got step=%0d state=%0d want 6 3", b0.step_o, b0.state_o); end
    #1 rst = 1'b1;
    #1;
    ncmp++; if (b0.spi_req_o !== 1'b0 || b0.spi_word_o !== 16'h0000) begin nerr++; $display("FAIL mid_rst_spi: got req=%b word=%h want 0 0000", b0.spi_req_o, b0.spi_word_o); end
    ncmp++; if (b0.busy_o !== 1'b0 || b0.done_o !== 1'b0 || b0.timeout_o !== 1'b0) begin nerr++; $display("FAIL mid_rst_flags: got busy=%b done=%b timeout=%b want 0 0 0", b0.busy_o, b0.done_o, b0.timeout_o); end
    ncmp++; if (b0.state_o !== 3'd0 || b0.step_o !== 5'd0) begin nerr++; $display("FAIL mid_rst_state: got %0d/%0d want 0/0", b0.state_o, b0.step_o); end
    @(negedge clk);
    rst = 1'b0;
    base = q0.size();
    repeat (60) @(negedge clk);
    ncmp++; if (q0.size() != base || b0.busy_o !== 1'b0) begin nerr++; $display("FAIL mid_no_resume: got reqs=%0d busy=%b want 0 0", q0.size() - base, b0.busy_o); end
  endtask

  task automatic test_lengths();
    int base2 = q2.size();
    int base3 = q3.size();
    int d2 = dn2;
    int d3 = dn3;
    int n = 0;
    b2.payload_i = 8'h7E; b2.start_i = 1'b1;
    b3.payload_i = 128'h00112233445566778899AABBCCDDEEFF; b3.start_i = 1'b1;
    @(negedge clk);
    b2.start_i = 1'b0; b3.start_i = 1'b0;
    while ((dn2 == d2 || dn3 == d3) && n < 1500) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    ncmp++; if (q2.size() != base2 + 9) begin nerr++; $display("FAIL p1_req_count: got %0d want 9", q2.size() - base2); end
    ncmp++; if (q2[base2 + 5] !== 16'hA201 || q2[base2 + 6] !== 16'h807E) begin nerr++; $display("FAIL p1_words: got %h %h want a201 807e", q2[base2 + 5], q2[base2 + 6]); end
    ncmp++; if (q3.size() != base3 + 24) begin nerr++; $display("FAIL p16_req_count: got %0d want 24", q3.size() - base3); end
    ncmp++; if (q3[base3 + 5] !== 16'hA210) begin nerr++; $display("FAIL p16_len_word: got %h want a210", q3[base3 + 5]); end
    ncmp++; if (q3[base3 + 6] !== 16'h8000 || q3[base3 + 13] !== 16'h8077 || q3[base3 + 21] !== 16'h80FF) begin nerr++; $display("FAIL p16_payload: got %h %h %h want 8000 8077 80ff", q3[base3 + 6], q3[base3 + 13], q3[base3 + 21]); end
    ncmp++; if (q3[base3 + 22] !== 16'h8183 || q3[base3 + 23] !== 16'h9208) begin nerr++; $display("FAIL p16_tail: got %h %h want 8183 9208", q3[base3 + 22], q3[base3 + 23]); end
    ncmp++; if (dn2 - d2 != 1 || dn3 - d3 != 1) begin nerr++; $display("FAIL plen_done: got %0d %0d want 1 1", dn2 - d2, dn3 - d3); end
  endtask

  initial begin
    b0.start_i = 1'b0; b0.payload_i = '0; b0.dio0_i = 1'b0;
    b1.start_i = 1'b0; b1.payload_i = '0; b1.dio0_i = 1'b0;
    b2.start_i = 1'b0; b2.payload_i = '0; b2.dio0_i = 1'b1;
    b3.start_i = 1'b0; b3.payload_i = '0; b3.dio0_i = 1'b1;
    test_reset();
    test_packet();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_lengths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
